alu_muldiv_iter: RTL and testbench
==================================

// Module: alu_muldiv_iter
// PURPOSE
//  Parametrised iterative multiply/divide unit with HI/LO result registers; EX-stage companion to the combinational ALUs.
//  Radix-2 shift-add multiply and restoring divide, signed and unsigned; MTHI/MTLO register writes.
//  Holds the pipeline via busy; flush aborts an in-flight operation.
// PARAMETERS
//  WIDTH   32  operand / HI / LO width (>=4)
//  CNT_W   $clog2(WIDTH+1)  localparam, iteration counter width
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      synchronous, active-high reset
//  start_i      in   1      request; accepted only when busy_o=0
//  op_i         in   3      0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved (ignored)
//  a_i          in   WIDTH  rs: multiplicand / dividend / MTHI-MTLO data
//  b_i          in   WIDTH  rt: multiplier / divisor
//  flush_i      in   1      abort current operation
//  busy_o       out  1      operation in flight; pipeline stall
//  done_o       out  1      one-cycle pulse: HI/LO just updated by MULT/DIV
//  div0_o       out  1      sticky until next accepted start: last DIV/DIVU had b=0
//  hi_o         out  WIDTH  HI register
//  lo_o         out  WIDTH  LO register
// BEHAVIOUR
//  Reset: state IDLE; busy_o=0, done_o=0, div0_o=0, hi_o=0, lo_o=0, counter=0.
//  FSM: IDLE -> CALC -> FIX -> IDLE.
//   IDLE: start_i & op in {0..3} at edge E0 -> latch |a|,|b| (signed ops) or a,b; record result signs; counter=WIDTH; CALC; busy_o=1.
//   IDLE: start_i & op 4/5 -> hi_o/lo_o <= a_i at that edge; no busy, no done. ops 6/7: no effect.
//   CALC: one iteration per edge, counter decrements; at edge E_WIDTH (counter 1->0) -> FIX.
//   FIX: edge E_WIDTH+1 applies sign correction, writes hi_o/lo_o, done_o=1 for the next cycle, busy_o=0, -> IDLE.
//  Latency: result visible WIDTH+1 cycles after accept edge; next start accepted in the done_o cycle.
//  start_i while busy_o=1: ignored, no queueing (pipeline is stalled, must hold request).
//  Multiply: {hi,lo} = full 2*WIDTH product; signed result negated iff sign(a)^sign(b).
//  Divide: lo=quotient, hi=remainder; truncate toward zero; quotient sign = sign(a)^sign(b), remainder sign = sign(a).
//  b=0 (DIV/DIVU): lo=all-ones, hi=a_i, div0_o=1; still full latency.
//  DIV of MIN by -1: lo=MIN (0x8..0), hi=0; no flag.
//  flush_i: in CALC/FIX -> IDLE next edge, busy_o=0, HI/LO unchanged, no done_o; flush_i with start_i in IDLE: start dropped.
//  rst overrides everything incl. mid-operation; HI/LO cleared.
//  Widths: internal accumulator WIDTH+1 bits for divide, 2*WIDTH for product; no overflow signalling.
// STRUCTURE
//  Shared package muldiv_pkg: op code localparams (OP_MULT..OP_MTLO), FSM state encodings.
//  One sub-module: muldiv_datapath (shift registers, add/subtract, sign fix); FSM, counter, HI/LO in top.
//  Abs/negate helpers as functions in datapath.
// TESTING (WIDTH=32 unless noted)
//  MULT a=-3 (0xFFFFFFFD), b=5 -> after 33 cycles done_o=1, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
//  MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; DIVU 100/7 -> lo=14, hi=2.
//  DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/-1 -> lo=0x80000000, hi=0, div0_o=0.
//  DIV 5/0 -> lo=0xFFFFFFFF, hi=5, div0_o=1; following MTLO 0x1234 -> lo=0x1234 next cycle, div0_o cleared.
//  MULT started, flush_i at cycle 10 -> busy_o=0 next cycle, no done_o, HI/LO keep previous values; start while busy ignored.
//  WIDTH=8: MULT -128*-128 -> hi=0x40, lo=0x00 after 9 cycles; rst mid-DIV -> all outputs 0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation codes, FSM state encoding and a small op classifier.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // True for the multi-cycle arithmetic ops (MULT, MULTU, DIV, DIVU).
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op <= OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface alu_muldiv_iter_if #(
  parameter int WIDTH = 32
);
  import muldiv_pkg::*;

  // Handshake: start_i is the request valid, ~busy_o is ready; a request is
  // taken on a rising edge where both hold, and the requester must keep
  // start_i/op_i/a_i/b_i stable while busy_o is high (nothing is queued).
  logic             start_i;
  logic [2:0]       op_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             flush_i;
  logic             busy_o;
  logic             done_o;
  logic             div0_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  state_t           state_dbg;

  modport master (
    output start_i, op_i, a_i, b_i, flush_i,
    input  busy_o, done_o, div0_o, hi_o, lo_o, state_dbg
  );

  modport slave (
    input  start_i, op_i, a_i, b_i, flush_i,
    output busy_o, done_o, div0_o, hi_o, lo_o, state_dbg
  );

endinterface

// File: rtl/muldiv_datapath.sv
// Shift registers and adder/subtractor for radix-2 shift-add multiply and
// restoring divide on operand magnitudes, plus the final sign correction.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             div0
);

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? negate(x) : x;
  endfunction

  // upper: product high half / partial remainder; lower: multiplier / quotient.
  logic [WIDTH-1:0] upper, lower, operand, a_orig;
  logic             is_div, neg_q, neg_r, zero_div;

  logic             op_signed, op_div;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [2*WIDTH-1:0] prod;

  assign op_signed = (op == OP_MULT[1:0]) || (op == OP_DIV[1:0]);
  assign op_div    = !((op == OP_MULT[1:0]) || (op == OP_MULTU[1:0]));

  assign mul_sum   = {1'b0, upper} + (lower[0] ? {1'b0, operand} : '0);
  // The remainder is always below the divisor, so the shifted value needs one extra bit.
  assign div_shift = {upper, lower[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, operand});
  assign div_rem   = div_shift[WIDTH-1:0] - operand;
  assign prod      = {upper, lower};

  always_ff @(posedge clk) begin
    if (rst) begin
      upper    <= '0;
      lower    <= '0;
      operand  <= '0;
      a_orig   <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      zero_div <= 1'b0;
    end else if (load) begin
      upper    <= '0;
      lower    <= abs_val(a, op_signed);
      operand  <= abs_val(b, op_signed);
      a_orig   <= a;
      is_div   <= op_div;
      neg_q    <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r    <= op_signed && a[WIDTH-1];
      zero_div <= op_div && (b == '0);
    end else if (step) begin
      if (is_div) begin
        upper <= div_ge ? div_rem : div_shift[WIDTH-1:0];
        lower <= {lower[WIDTH-2:0], div_ge};
      end else begin
        upper <= mul_sum[WIDTH:1];
        lower <= {mul_sum[0], lower[WIDTH-1:1]};
      end
    end
  end

  always_comb begin
    res_hi = upper;
    res_lo = lower;
    if (!is_div) begin
      {res_hi, res_lo} = neg_q ? (~prod + (2*WIDTH)'(1)) : prod;
    end else if (zero_div) begin
      res_hi = a_orig;
      res_lo = '1;
    end else begin
      res_lo = neg_q ? negate(lower) : lower;
      res_hi = neg_r ? negate(upper) : upper;
    end
  end

  assign div0 = zero_div;

endmodule

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply/divide unit with HI/LO registers; stalls the pipeline
// through busy_o and can be aborted by flush_i.
module alu_muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  alu_muldiv_iter_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             accept, load, step, fix_write;
  logic [WIDTH-1:0] hi_q, lo_q, res_hi, res_lo;
  logic             done_q, div0_q, dp_div0;

  muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (step),
    .op     (bus.op_i[1:0]),
    .a      (bus.a_i),
    .b      (bus.b_i),
    .res_hi (res_hi),
    .res_lo (res_lo),
    .div0   (dp_div0)
  );

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    fix_write = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // A flush in the same cycle drops the request entirely.
        if (bus.start_i && !bus.flush_i && (bus.op_i <= OP_MTLO)) begin
          accept = 1'b1;
          if (is_muldiv(bus.op_i)) begin
            load    = 1'b1;
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        if (bus.flush_i) begin
          state_d = ST_IDLE;
        end else begin
          step = 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        state_d   = ST_IDLE;
        fix_write = !bus.flush_i;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= fix_write;
      if (load)      cnt_q <= CNT_W'(WIDTH);
      else if (step) cnt_q <= cnt_q - CNT_W'(1);
      else           cnt_q <= '0;
      if (accept) div0_q <= 1'b0;
      if (accept && (bus.op_i == OP_MTHI)) hi_q <= bus.a_i;
      if (accept && (bus.op_i == OP_MTLO)) lo_q <= bus.a_i;
      if (fix_write) begin
        hi_q   <= res_hi;
        lo_q   <= res_lo;
        div0_q <= dp_div0;
      end
    end
  end

  assign bus.busy_o    = (state_q != ST_IDLE);
  assign bus.done_o    = done_q;
  assign bus.div0_o    = div0_q;
  assign bus.hi_o      = hi_q;
  assign bus.lo_o      = lo_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_alu_muldiv_iter.sv
// Directed and random checks of alu_muldiv_iter at WIDTH=32 and WIDTH=8,
// with a scoreboard of expected {div0, hi, lo} results.
module tb_alu_muldiv_iter;
  import muldiv_pkg::*;

  logic clk, rst, rst8;
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  int   t_issue = 0;
  logic [64:0] exp_q[$];

  alu_muldiv_iter_if #(.WIDTH(32)) bus  ();
  alu_muldiv_iter_if #(.WIDTH(8))  bus8 ();

  alu_muldiv_iter #(.WIDTH(32)) dut   (.clk(clk), .rst(rst),  .bus(bus.slave));
  alu_muldiv_iter #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst8), .bus(bus8.slave));

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [64:0] observed(input bit w8);
    if (w8) return {bus8.div0_o, 24'd0, bus8.hi_o, 24'd0, bus8.lo_o};
    return {bus.div0_o, bus.hi_o, bus.lo_o};
  endfunction

  function automatic logic [64:0] model32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    case (op)
      OP_MULT:  begin p = sa * sb; return {1'b0, p}; end
      OP_MULTU: begin p = {32'd0, a} * {32'd0, b}; return {1'b0, p}; end
      OP_DIV: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a falling edge; the request is taken on the following rising edge.
  task automatic issue(input bit w8, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (w8) begin
      bus8.start_i = 1'b1; bus8.op_i = op; bus8.a_i = a[7:0]; bus8.b_i = b[7:0];
    end else begin
      bus.start_i = 1'b1; bus.op_i = op; bus.a_i = a; bus.b_i = b;
    end
    @(negedge clk);
    t_issue = cyc;
    bus.start_i  = 1'b0;
    bus8.start_i = 1'b0;
  endtask

  task automatic wait_done(input bit w8, input string tag, input int lat);
    int          n;
    logic        got;
    logic [64:0] exp;
    n = 0;
    got = 1'b0;
    while (!got && n < 100) begin
      if (w8 ? bus8.done_o : bus.done_o) got = 1'b1;
      else begin @(negedge clk); n++; end
    end
    check({tag, "_lat"}, 65'(cyc - t_issue), 65'(got ? lat : -1));
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    check({tag, "_res"}, observed(w8), exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          dones;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    bus.start_i = 0;  bus.op_i = 0;  bus.a_i = 0;  bus.b_i = 0;  bus.flush_i = 0;
    bus8.start_i = 0; bus8.op_i = 0; bus8.a_i = 0; bus8.b_i = 0; bus8.flush_i = 0;
    rst = 1'b1;
    rst8 = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rst8 = 1'b0;

    check("reset_regs",  observed(1'b0), '0);
    check("reset_ctl",   65'({bus.busy_o, bus.done_o}), '0);
    check("reset_state", 65'(bus.state_dbg), 65'(ST_IDLE));
    check("reset8_regs", observed(1'b1), '0);

    exp_q.push_back({1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1});
    issue(0, OP_MULT, 32'hFFFF_FFFD, 32'd5);
    check("mult_busy", 65'(bus.busy_o), 65'd1);
    wait_done(0, "mult_neg", 33);

    exp_q.push_back({1'b0, 32'hFFFF_FFFE, 32'h0000_0001});
    issue(0, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(0, "multu_max", 33);

    exp_q.push_back({1'b0, 32'd2, 32'd14});
    issue(0, OP_DIVU, 32'd100, 32'd7);
    wait_done(0, "divu_100_7", 33);

    exp_q.push_back({1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    issue(0, OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(0, "div_m7_2", 33);

    exp_q.push_back({1'b0, 32'h0, 32'h8000_0000});
    issue(0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(0, "div_min_m1", 33);

    exp_q.push_back({1'b1, 32'd5, 32'hFFFF_FFFF});
    issue(0, OP_DIV, 32'd5, 32'd0);
    wait_done(0, "div_by0", 33);

    issue(0, OP_MTLO, 32'h1234, 32'd0);
    check("mtlo", observed(1'b0), {1'b0, 32'd5, 32'h1234});
    issue(0, OP_MTHI, 32'hABCD, 32'd0);
    check("mthi", observed(1'b0), {1'b0, 32'hABCD, 32'h1234});
    issue(0, 3'd6, 32'hFFFF_FFFF, 32'd1);
    check("op6_regs", observed(1'b0), {1'b0, 32'hABCD, 32'h1234});
    check("op6_busy", 65'(bus.busy_o), 65'd0);

    // Flush mid-multiply; a start raised while busy must be ignored.
    issue(0, OP_MULT, 32'd7, 32'd9);
    bus.start_i = 1'b1; bus.op_i = OP_MTHI; bus.a_i = 32'h5555;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (7) @(negedge clk);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    check("flush_busy", 65'(bus.busy_o), 65'd0);
    dones = 0;
    repeat (40) begin
      dones += int'(bus.done_o);
      @(negedge clk);
    end
    check("flush_nodone", 65'(dones), 65'd0);
    check("flush_regs", observed(1'b0), {1'b0, 32'hABCD, 32'h1234});

    bus.flush_i = 1'b1;
    issue(0, OP_MTHI, 32'h7777, 32'd0);
    bus.flush_i = 1'b0;
    check("flush_start_drop", observed(1'b0), {1'b0, 32'hABCD, 32'h1234});

    exp_q.push_back({1'b0, 32'd0, 32'd42});
    issue(0, OP_MULT, 32'd6, 32'd7);
    bus.start_i = 1'b1; bus.op_i = OP_MTLO; bus.a_i = 32'h9999;
    @(negedge clk);
    bus.start_i = 1'b0;
    check("busy_start_ign", observed(1'b0), {1'b0, 32'hABCD, 32'h1234});
    wait_done(0, "mult_6_7", 33);

    // Back-to-back random ops: each is issued in the done cycle of the last.
    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(0, 15));
      if (i == 3) rb = 32'hFFFF_FFFF - rb;
      exp_q.push_back(model32(rop, ra, rb));
      issue(0, rop, ra, rb);
      wait_done(0, $sformatf("rand%0d_op%0d", i, rop), 33);
    end

    exp_q.push_back({1'b0, 24'd0, 8'h40, 24'd0, 8'h00});
    issue(1, OP_MULT, 32'h80, 32'h80);
    wait_done(1, "w8_mult_min", 9);

    exp_q.push_back({1'b0, 24'd0, 8'hFF, 24'd0, 8'hFD});
    issue(1, OP_DIV, 32'hF9, 32'd2);
    wait_done(1, "w8_div_m7_2", 9);

    issue(1, OP_DIV, 32'd100, 32'd3);
    repeat (3) @(negedge clk);
    rst8 = 1'b1;
    @(negedge clk);
    rst8 = 1'b0;
    check("w8_rst_regs", observed(1'b1), '0);
    check("w8_rst_ctl", 65'({bus8.busy_o, bus8.done_o}), '0);
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      dones += int'(bus8.done_o);
    end
    check("w8_rst_nodone", 65'(dones), 65'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
